// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: mode encoding shared by the pipelined approximate adder and its users
package approx_adder_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_EXACT = 2'b00;
    localparam mode_t MODE_LOA   = 2'b01;
    localparam mode_t MODE_TRUNC = 2'b10;
    localparam mode_t MODE_RSVD  = 2'b11;
endpackage

// File: rtl/approx_adder_segment.sv
// approx_adder_segment: one ripple segment; bits below APPROX_BITS (by global index) are
// OR-ed (LOA) or zeroed (truncate) instead of added
module approx_adder_segment
    import approx_adder_pkg::*;
#(
    parameter int SEG_WIDTH   = 8,
    parameter int APPROX_BITS = 8
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    input  mode_t                mode,
    input  logic [31:0]          base,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout
);
    logic [SEG_WIDTH:0] c;
    logic               approx_mode;
    assign c[0]        = cin;
    assign approx_mode = (mode == MODE_LOA) || (mode == MODE_TRUNC);
    for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
        logic approx;
        logic top_low;
        assign approx  = approx_mode && (base + 32'(i) < 32'(APPROX_BITS));
        assign top_low = base + 32'(i) == 32'(APPROX_BITS - 1);
        // LOA feeds the exact upper part with the AND of the top approximate bit pair
        assign sum[i]   = !approx ? a[i] ^ b[i] ^ c[i] : (mode == MODE_LOA) ? a[i] | b[i] : 1'b0;
        assign c[i+1]   = !approx ? (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
                        : (mode == MODE_LOA && top_low) ? a[i] & b[i] : 1'b0;
    end
    assign cout = c[SEG_WIDTH];
endmodule

// File: rtl/pipelined_approx_adder.sv
// pipelined_approx_adder: WIDTH-bit adder split into register-separated ripple segments with
// valid/ready flow control and per-transaction exact / LOA / truncate modes
module pipelined_approx_adder
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SEG_WIDTH   = 8,
    parameter int APPROX_BITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o,
    output logic [1:0]       mode_o
);
    localparam int NSEG = WIDTH / SEG_WIDTH;
    if (WIDTH % SEG_WIDTH != 0) begin : g_bad_seg
        $error("WIDTH must be a multiple of SEG_WIDTH");
    end
    if (APPROX_BITS < 1 || APPROX_BITS > WIDTH) begin : g_bad_approx
        $error("APPROX_BITS must be in 1..WIDTH");
    end
    logic [NSEG-1:0] v;
    logic [NSEG-1:0] adv;
    // A stage advances when empty, or when the stage ahead is empty or itself advancing
    always_comb begin
        adv = '0;
        adv[NSEG-1] = !v[NSEG-1] || ready_i;
        for (int s = NSEG - 2; s >= 0; s--) adv[s] = !v[s] || !v[s+1] || adv[s+1];
    end
    assign ready_o = adv[0] || !v[0];
    for (genvar s = 0; s < NSEG; s++) begin : g_stage
        localparam int OW = WIDTH - s * SEG_WIDTH;
        localparam int SW = (s + 1) * SEG_WIDTH;
        logic [OW-1:0]        a_in;
        logic [OW-1:0]        b_in;
        logic                 c_in;
        logic                 v_in;
        mode_t                m_in;
        logic [SEG_WIDTH-1:0] seg_sum;
        logic                 seg_cout;
        logic [SW-1:0]        s_nxt;
        logic                 v_q;
        logic                 c_q;
        mode_t                m_q;
        logic [SW-1:0]        s_q;
        if (s == 0) begin : g_in
            assign a_in  = add1_i;
            assign b_in  = add2_i;
            assign c_in  = 1'b0;
            assign v_in  = valid_i;
            assign m_in  = mode_i;
            assign s_nxt = seg_sum;
        end else begin : g_in
            assign a_in  = g_stage[s-1].g_ops.a_q;
            assign b_in  = g_stage[s-1].g_ops.b_q;
            assign c_in  = g_stage[s-1].c_q;
            assign v_in  = g_stage[s-1].v_q;
            assign m_in  = g_stage[s-1].m_q;
            assign s_nxt = {seg_sum, g_stage[s-1].s_q};
        end
        approx_adder_segment #(.SEG_WIDTH(SEG_WIDTH), .APPROX_BITS(APPROX_BITS)) u_seg (
            .a(a_in[SEG_WIDTH-1:0]),
            .b(b_in[SEG_WIDTH-1:0]),
            .cin(c_in),
            .mode(m_in),
            .base(32'(s * SEG_WIDTH)),
            .sum(seg_sum),
            .cout(seg_cout)
        );
        // Operand slices not yet consumed ride along to later segments
        if (s < NSEG - 1) begin : g_ops
            logic [OW-SEG_WIDTH-1:0] a_q;
            logic [OW-SEG_WIDTH-1:0] b_q;
            always_ff @(posedge clk_i or posedge rst_i)
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[s] && v_in) begin
                    a_q <= a_in[OW-1:SEG_WIDTH];
                    b_q <= b_in[OW-1:SEG_WIDTH];
                end
        end
        always_ff @(posedge clk_i or posedge rst_i)
            if (rst_i) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                m_q <= MODE_EXACT;
                s_q <= '0;
            end else if (adv[s]) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= seg_cout;
                    m_q <= m_in;
                    s_q <= s_nxt;
                end
            end
        assign v[s] = v_q;
    end
    assign valid_o  = v[NSEG-1];
    assign result_o = {g_stage[NSEG-1].c_q, g_stage[NSEG-1].s_q};
    assign mode_o   = g_stage[NSEG-1].m_q;
endmodule
